data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 160 ++++++++++++++++
 tb/tb_data_cache.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// data_cache -- direct-mapped, write-through, no-write-allocate data cache
// for the MEM stage. There are 8 lines of 4 x 32-bit words. A read miss
// stalls the pipeline while the line is filled from the backing block.
//
// Ports
//   clk          single clock; all state changes on the rising edge
//   rst          synchronous, active-low reset
//   address      word address (byte address [31:2])
//   mem_read     load request
//   mem_write    store request (takes priority over mem_read)
//   write_data   store data
//   mem_in       backing-memory block {word3,word2,word1,word0} at fill_addr
//   fill_addr    block address of the line being filled, bits [1:0] = 00
//   mem_wr_en    registered one-cycle write-through strobe
//   mem_wr_addr  write-through word address
//   mem_wr_data  write-through data
//   read_data    load result (0 unless this cycle is a read hit)
//   data_hit     access complete / pipeline-advance enable
//   state_dbg    current FSM state (0 = IDLE, 1 = FILL)
//
// Request/complete handshake: the MEM stage holds mem_read/mem_write and
// address stable while data_hit is low. An access completes in the cycle
// where data_hit is high. A write or an idle cycle completes at once. A read
// completes on a hit, so a missing read stays low through the fill and
// then completes as a hit on the refilled line.
module data_cache #(
  parameter int MISS_LATENCY = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [29:0]  address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  write_data,
  input  logic [127:0] mem_in,
  output logic [29:0]  fill_addr,
  output logic         mem_wr_en,
  output logic [29:0]  mem_wr_addr,
  output logic [31:0]  mem_wr_data,
  output logic [31:0]  read_data,
  output logic         data_hit,
  output logic         state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [3:0] LAT = 4'(MISS_LATENCY);

  state_t state;
  state_t state_next;
  logic [3:0] count;
  logic start_fill;

  logic [127:0] line_data [8];
  logic [24:0]  line_tag  [8];
  logic [7:0]   line_valid;

  logic [2:0]   idx;
  logic [1:0]   sel;
  logic [24:0]  tag;
  logic [127:0] cur_line;
  logic [31:0]  cur_word;
  logic         hit;
  logic [2:0]   fill_idx;
  logic [24:0]  fill_tag;
  logic         fill_done;
  logic         is_read;
  logic         accept_write;

  assign idx      = address[4:2];
  assign sel      = address[1:0];
  assign tag      = address[29:5];
  assign cur_line = line_data[idx];
  assign cur_word = cur_line[{sel, 5'd0} +: 32];
  assign hit      = line_valid[idx] && (line_tag[idx] == tag);

  assign fill_idx  = fill_addr[4:2];
  assign fill_tag  = fill_addr[29:5];
  assign fill_done = (state == FILL) && (count == LAT);

  // A simultaneous read and write is treated purely as a write.
  assign is_read      = mem_read && !mem_write;
  assign accept_write = (state == IDLE) && mem_write;

  assign state_dbg = state;

  always_comb begin
    state_next = state;
    data_hit   = 1'b1;
    read_data  = 32'd0;
    start_fill = 1'b0;
    case (state)
      IDLE: begin
        if (is_read) begin
          if (hit) begin
            read_data = cur_word;
          end else begin
            data_hit   = 1'b0;
            start_fill = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        // Requests are ignored here. The fill uses the latched fill_addr.
        data_hit = 1'b0;
        if (count == LAT) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= 4'd0;
      fill_addr   <= 30'd0;
      line_valid  <= 8'd0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= 30'd0;
      mem_wr_data <= 32'd0;
    end else begin
      state     <= state_next;
      mem_wr_en <= accept_write;
      if (accept_write) begin
        mem_wr_addr <= address;
        mem_wr_data <= write_data;
      end
      if (start_fill) begin
        fill_addr <= {address[29:2], 2'b00};
        count     <= 4'd1;
      end else if (state == FILL) begin
        if (fill_done) begin
          count                <= 4'd0;
          line_valid[fill_idx] <= 1'b1;
        end else begin
          count <= count + 4'd1;
        end
      end
    end
  end

  // The data and tag arrays are not reset. The valid bits alone decide
  // whether a line is usable. These writes are gated by rst so that a
  // reset landing on the final FILL edge abandons the fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (fill_done) begin
        line_data[fill_idx] <= mem_in;
        line_tag[fill_idx]  <= fill_tag;
      end else if (accept_write && hit) begin
        line_data[idx][{sel, 5'd0} +: 32] <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache: cold miss, conflict eviction, write
// hit/miss with write-through pulses, read+write priority, reset mid-fill,
// and an address change during a fill.
module tb_data_cache;

  localparam int LAT = 3;

  logic         clk;
  logic         rst;
  logic [29:0]  address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  write_data;
  logic [127:0] mem_in;
  logic [29:0]  fill_addr;
  logic         mem_wr_en;
  logic [29:0]  mem_wr_addr;
  logic [31:0]  mem_wr_data;
  logic [31:0]  read_data;
  logic         data_hit;
  logic         state_dbg;

  int total = 0;
  int bad   = 0;
  logic [61:0] exp_q[$];

  localparam logic [31:0] WA = 32'h1111_000A, WB = 32'h2222_000B;
  localparam logic [31:0] WC = 32'h3333_000C, WD = 32'h4444_000D;
  localparam logic [31:0] WE = 32'h5555_000E, WF = 32'h6666_000F;
  localparam logic [31:0] WG = 32'h7777_0010, WH = 32'h8888_0011;
  localparam logic [127:0] BLK0 = {WD, WC, WB, WA};
  localparam logic [127:0] BLK1 = {WH, WG, WF, WE};
  localparam logic [127:0] BLK2 = {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000};
  localparam logic [127:0] BLK3 = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};

  data_cache #(.MISS_LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .write_data  (write_data),
    .mem_in      (mem_in),
    .fill_addr   (fill_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .read_data   (read_data),
    .data_hit    (data_hit),
    .state_dbg   (state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks. Inputs change at posedge+1 and outputs are checked on the
  // negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
    mem_read   = rd;
    mem_write  = wr;
    address    = a;
    write_data = wd;
    if (wr) exp_q.push_back({a, wd});
  endtask

  task automatic hit_read(input string tag, input logic [29:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'd0);
    @(negedge clk);
    check({tag, "_hit"}, data_hit, 1'b1);
    check({tag, "_data"}, read_data, exp);
    tick();
    idle_in();
  endtask

  task automatic write_word(input string tag, input logic [29:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    @(negedge clk);
    check({tag, "_hit"}, data_hit, 1'b1);
    tick();
    idle_in();
  endtask

  // Full read miss. The bench expects data_hit low for LAT+1 cycles and
  // then a hit. When alt differs from a, address and requests are scrambled
  // during FILL, and these must have no effect.
  task automatic miss_read(input string tag, input logic [29:0] a, input logic [29:0] alt,
                           input logic [127:0] blk, input logic [31:0] exp);
    mem_in = blk;
    drive(1'b1, 1'b0, a, 32'd0);
    @(negedge clk);
    check({tag, "_miss_hit"}, data_hit, 1'b0);
    check({tag, "_miss_data"}, read_data, 32'd0);
    tick();
    for (int i = 1; i <= LAT; i++) begin
      if (alt != a) begin
        address    = alt;
        mem_read   = i[0];
        mem_write  = ~i[0];
        write_data = $urandom;
      end
      @(negedge clk);
      check({tag, "_fill_hit"}, data_hit, 1'b0);
      check({tag, "_fill_addr"}, fill_addr, {a[29:2], 2'b00});
      tick();
    end
    drive(1'b1, 1'b0, a, 32'd0);
    @(negedge clk);
    check({tag, "_done_hit"}, data_hit, 1'b1);
    check({tag, "_done_data"}, read_data, exp);
    tick();
    idle_in();
  endtask

  // Scoreboard for write-through pulses. Every accepted write pushes its
  // {addr,data} entry, and every cycle with mem_wr_en high must pop one.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", mem_wr_addr, 30'h3fff_ffff);
      end else begin
        logic [61:0] e;
        e = exp_q.pop_front();
        check("wr_addr", mem_wr_addr, e[61:32]);
        check("wr_data", mem_wr_data, e[31:0]);
      end
    end
  end

  initial begin
    rst        = 1'b0;
    address    = 30'd0;
    write_data = 32'd0;
    mem_in     = 128'd0;
    idle_in();

    // Reset state.
    tick();
    @(negedge clk);
    check("rst_hit", data_hit, 1'b1);
    check("rst_data", read_data, 32'd0);
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_fill_addr", fill_addr, 30'd0);
    tick();
    rst = 1'b1;

    // Cold miss, hits in the same line, conflict eviction, then a refill.
    miss_read("cold10", 30'h10, 30'h10, BLK0, WA);
    hit_read("rd13", 30'h13, WD);
    hit_read("rd11", 30'h11, WB);
    hit_read("rd12", 30'h12, WC);
    miss_read("conf30", 30'h30, 30'h30, BLK1, WE);
    hit_read("rd31", 30'h31, WF);
    miss_read("refill10", 30'h10, 30'h10, BLK0, WA);

    // Write hits, including back-to-back writes, followed by reads.
    write_word("wr11", 30'h11, 32'hDEAD_BEEF);
    hit_read("rd11new", 30'h11, 32'hDEAD_BEEF);
    write_word("wr12", 30'h12, 32'h1234_5678);
    write_word("wr13", 30'h13, 32'hCAFE_F00D);
    hit_read("rd12new", 30'h12, 32'h1234_5678);
    hit_read("rd13new", 30'h13, 32'hCAFE_F00D);
    hit_read("rd10", 30'h10, WA);

    // Read and write together: the access must act as a write only.
    drive(1'b1, 1'b1, 30'h10, 32'h0BAD_F00D);
    @(negedge clk);
    check("both_hit", data_hit, 1'b1);
    check("both_data", read_data, 32'd0);
    tick();
    idle_in();
    hit_read("rd10both", 30'h10, 32'h0BAD_F00D);

    // Write miss: no allocate, and the resident line is left untouched.
    write_word("wr50", 30'h50, 32'h5555_5555);
    hit_read("rd10keep", 30'h10, 32'h0BAD_F00D);
    miss_read("miss50", 30'h50, 30'h50, BLK2, 32'h9999_0000);
    @(negedge clk);
    check("idle_wr_en", mem_wr_en, 1'b0);
    tick();

    // Reset in the second FILL cycle.
    mem_in = BLK3;
    drive(1'b1, 1'b0, 30'h08, 32'd0);
    @(negedge clk);
    check("rstf_miss_hit", data_hit, 1'b0);
    tick();
    @(negedge clk);
    check("rstf_fill1_hit", data_hit, 1'b0);
    tick();
    rst = 1'b0;
    idle_in();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rstf_after_hit", data_hit, 1'b1);
    check("rstf_after_data", read_data, 32'd0);
    check("rstf_after_fill_addr", fill_addr, 30'd0);
    check("rstf_after_state", state_dbg, 1'b0);
    tick();
    miss_read("reread08", 30'h08, 30'h08, BLK3, 32'hAAAA_0000);
    miss_read("cleared10", 30'h10, 30'h10, BLK0, WA);

    // Address changes during FILL. The latched block must be the one filled.
    miss_read("alt20", 30'h20, 30'h64, BLK0, WA);
    hit_read("rd22", 30'h22, WC);
    miss_read("miss64", 30'h64, 30'h64, BLK1, WE);
    hit_read("rd23", 30'h23, WD);

    tick();
    tick();
    check("wr_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
